// File: rtl/ff_pkg.sv
// Shared definitions for the ff_bank state-register primitive: mode encodings
// and a width-bounded population count.
package ff_pkg;

    localparam logic [1:0] MODE_JK = 2'd0;
    localparam logic [1:0] MODE_SR = 2'd1;
    localparam logic [1:0] MODE_D  = 2'd2;
    localparam logic [1:0] MODE_T  = 2'd3;

    // Widest vector popcount accepts; callers zero-extend and pass their real width.
    localparam int unsigned POP_MAX_W = 256;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v,
                                             input int unsigned          n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            if ((i < n) && v[i]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ff_lane.sv
// Combinational next-state for one flip-flop lane under JK/SR/D/T behaviour,
// plus a flag for the illegal S=R=1 combination.
module ff_lane
    import ff_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    input  logic       q,
    output logic       q_nxt,
    output logic       illegal
);

    always_comb begin
        q_nxt   = q;
        illegal = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   q_nxt = ~q;
                    default: q_nxt = q;
                endcase
            end
            MODE_SR: begin
                // S=R=1 keeps the lane unchanged and only raises the flag.
                case ({j, k})
                    2'b10:   q_nxt = 1'b1;
                    2'b01:   q_nxt = 1'b0;
                    2'b11:   illegal = 1'b1;
                    default: q_nxt = q;
                endcase
            end
            MODE_D:  q_nxt = j;
            MODE_T:  q_nxt = q ^ j;
            default: q_nxt = q;
        endcase
    end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH flip-flop lanes with selectable JK/SR/D/T behaviour, parallel
// load, change mask, sticky SR-illegal flag and saturating transition counter.
module ff_bank
    import ff_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      CNT_W   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] changed,
    output logic             sr_err,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int unsigned PC_W  = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The sum is one bit wider than either operand so overflow is visible before clamping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
        return s[CNT_W-1:0];
    endfunction

    logic [WIDTH-1:0] lane_nxt;
    logic [WIDTH-1:0] lane_ill;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ff_lane u_lane (
            .mode    (mode),
            .j       (j[i]),
            .k       (k[i]),
            .q       (q[i]),
            .q_nxt   (lane_nxt[i]),
            .illegal (lane_ill[i])
        );
    end

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] chg_next;
    logic             err_set;
    logic [PC_W-1:0]  chg_pop;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        q_next  = q;
        err_set = 1'b0;
        if (load) begin
            q_next = load_data;
        end else if (en) begin
            q_next  = lane_nxt;
            err_set = (mode == MODE_SR) && (|lane_ill);
        end
        chg_next = q ^ q_next;
        chg_pop  = PC_W'(popcount(POP_MAX_W'(chg_next), WIDTH));
        cnt_next = sat_add(toggle_cnt, chg_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= RST_VAL;
            changed    <= '0;
            sr_err     <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            q          <= q_next;
            changed    <= chg_next;
            // A new illegal SR input outranks a simultaneous clear.
            sr_err     <= err_set | (sr_err & ~err_clr);
            toggle_cnt <= cnt_next;
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_ff_bank.sv
// Scoreboard bench for ff_bank (WIDTH=8, CNT_W=4): the driver queues the
// expected post-edge state, the monitor pops and compares after each edge.
module tb_ff_bank;

    logic       clk = 1'b0;
    logic       rst, en, load, err_clr;
    logic [1:0] mode;
    logic [7:0] j, k, load_data;
    logic [7:0] q, q_n, changed;
    logic       sr_err;
    logic [3:0] toggle_cnt;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic [7:0] chg;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ff_bank #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .j          (j),
        .k          (k),
        .load       (load),
        .load_data  (load_data),
        .err_clr    (err_clr),
        .q          (q),
        .q_n        (q_n),
        .changed    (changed),
        .sr_err     (sr_err),
        .toggle_cnt (toggle_cnt)
    );

    task automatic check8(input string name, input string field,
                          input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Monitor: every edge that has a queued expectation is checked 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check8(e.name, "q",          q,                 e.q);
            check8(e.name, "q_n",        q_n,               ~e.q);
            check8(e.name, "changed",    changed,           e.chg);
            check8(e.name, "sr_err",     {7'd0, sr_err},    {7'd0, e.err});
            check8(e.name, "toggle_cnt", {4'd0, toggle_cnt}, {4'd0, e.cnt});
        end
    end

    task automatic step(input string name,
                        input logic r, input logic ld, input logic [7:0] ldd,
                        input logic e, input logic [1:0] m,
                        input logic [7:0] jj, input logic [7:0] kk, input logic clr,
                        input logic [7:0] eq, input logic [7:0] echg,
                        input logic eerr, input logic [3:0] ecnt);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; load_data = ldd; en = e; mode = m;
        j = jj; k = kk; err_clr = clr;
        x.name = name; x.q = eq; x.chg = echg; x.err = eerr; x.cnt = ecnt;
        sb.push_back(x);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; err_clr = 1'b0;
        mode = 2'd0; j = '0; k = '0; load_data = '0;

        //    name        rst ld  ldd    en mode  j      k      clr   q      chg    err   cnt
        step("reset",     1, 0, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0,  8'h00, 8'h00, 0, 4'd0);
        step("load_a5",   0, 1, 8'hA5, 0, 2'd0, 8'h00, 8'h00, 0,  8'hA5, 8'hA5, 0, 4'd4);
        step("jk_f0",     0, 0, 8'h00, 1, 2'd0, 8'hF0, 8'h0F, 0,  8'hF0, 8'h55, 0, 4'd8);
        step("sr_ill",    0, 0, 8'h00, 1, 2'd1, 8'h81, 8'h01, 0,  8'hF0, 8'h00, 1, 4'd8);
        step("sr_setwin", 0, 0, 8'h00, 1, 2'd1, 8'h81, 8'h01, 1,  8'hF0, 8'h00, 1, 4'd8);
        step("err_clr",   0, 0, 8'h00, 0, 2'd1, 8'h81, 8'h01, 1,  8'hF0, 8'h00, 0, 4'd8);
        step("load_00",   0, 1, 8'h00, 0, 2'd3, 8'hFF, 8'h00, 0,  8'h00, 8'hF0, 0, 4'd12);
        step("t_1",       0, 0, 8'h00, 1, 2'd3, 8'hFF, 8'h00, 0,  8'hFF, 8'hFF, 0, 4'd15);
        step("t_2",       0, 0, 8'h00, 1, 2'd3, 8'hFF, 8'h00, 0,  8'h00, 8'hFF, 0, 4'd15);
        step("t_3",       0, 0, 8'h00, 1, 2'd3, 8'hFF, 8'h00, 0,  8'hFF, 8'hFF, 0, 4'd15);
        step("d_en0",     0, 0, 8'h00, 0, 2'd2, 8'h3C, 8'h00, 0,  8'hFF, 8'h00, 0, 4'd15);
        step("d_en0_ld",  0, 1, 8'h11, 0, 2'd2, 8'h3C, 8'h00, 0,  8'h11, 8'hEE, 0, 4'd15);
        step("load_ff",   0, 1, 8'hFF, 0, 2'd0, 8'h00, 8'h00, 0,  8'hFF, 8'hEE, 0, 4'd15);
        step("rst_ovr",   1, 1, 8'h5A, 1, 2'd3, 8'hFF, 8'h00, 0,  8'h00, 8'h00, 0, 4'd0);
        step("d_3c",      0, 0, 8'h00, 1, 2'd2, 8'h3C, 8'h00, 0,  8'h3C, 8'h3C, 0, 4'd4);
        step("jk_tog",    0, 0, 8'h00, 1, 2'd0, 8'hFF, 8'hFF, 0,  8'hC3, 8'hFF, 0, 4'd12);
        step("sr_ill2",   0, 0, 8'h00, 1, 2'd1, 8'h01, 8'h01, 0,  8'hC3, 8'h00, 1, 4'd12);
        step("ld_keeperr",0, 1, 8'h00, 1, 2'd1, 8'h01, 8'h01, 0,  8'h00, 8'hC3, 1, 4'd15);
        step("sr_en0",    0, 0, 8'h00, 0, 2'd1, 8'hFF, 8'hFF, 1,  8'h00, 8'h00, 0, 4'd15);

        @(negedge clk);
        rst = 1'b0; load = 1'b0; en = 1'b0; err_clr = 1'b0;
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of WIDTH independent flip-flop lanes. A 2-bit mode input selects JK, SR, D or T next-state behaviour for all lanes. Adds parallel load, a per-cycle change mask, a sticky SR-illegal error flag and a saturating transition counter. Serves as the general-purpose state-register primitive for control logic that previously used single-bit JK flops.

## Interface
Parameters:
- WIDTH, 8: number of lanes.
- CNT_W, 16: width of the transition counter.
- RST_VAL, {WIDTH{1'b0}}: value loaded into q on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  update enable for mode-based next-state.
- mode  in  2  0=JK, 1=SR, 2=D, 3=T.
- j  in  WIDTH  J / S / D / T input per lane, depending on mode.
- k  in  WIDTH  K / R input per lane; ignored in D and T modes.
- load  in  1  parallel load strobe.
- load_data  in  WIDTH  value written to q on load.
- err_clr  in  1  clears sr_err.
- q  out  WIDTH  lane state.
- q_n  out  WIDTH  ~q, combinational from q.
- changed  out  WIDTH  registered mask of lanes whose q changed on the last edge.
- sr_err  out  1  sticky flag for an illegal SR input seen while updating.
- toggle_cnt  out  CNT_W  saturating count of total lane transitions.

## Operation
- Priority per edge: rst > load > en > hold.
- rst: q=RST_VAL, changed=0, sr_err=0, toggle_cnt=0.
- load (rst=0): q=load_data regardless of en and mode. changed=q^load_data. sr_err is not affected by load.
- en=1, load=0, per lane i:
  - JK: 00 hold, 10 set, 01 clear, 11 toggle.
  - SR: S=j[i], R=k[i]. 10 set, 01 clear, 00 hold. 11 holds the lane and sets sr_err.
  - D: q[i]=j[i].
  - T: j[i]=1 toggles the lane; j[i]=0 holds it.
- en=0, load=0: q holds, changed=0, no error detection.
- sr_err: sets on any lane with S=R=1 in SR mode while the update path is active (en=1, load=0, rst=0). Cleared by err_clr. If a set and err_clr occur on the same edge, the set wins. Otherwise sr_err holds.
- toggle_cnt: on each edge (rst=0), adds popcount of the next value of changed. Saturates at 2^CNT_W-1 and does not wrap.
- mode may change on any cycle; the value sampled on the edge governs that edge only.

## Timing
- Single-cycle latency. Inputs sampled at edge N appear on q and changed after edge N.
- toggle_cnt reflects transitions through edge N on the same cycle as changed (same edge, not one later).
- q_n is combinational from registered q; no extra delay.
- Reset mid-operation: takes effect on the next edge and overrides load and en. All outputs reach reset values after that edge.
- No handshake. load is a level sampled each edge; holding load high reloads every cycle.

## Structure
- Shared package ff_pkg holds:
  - mode constants MODE_JK=2'd0, MODE_SR=2'd1, MODE_D=2'd2, MODE_T=2'd3;
  - a popcount function parametrised by width.
- Sub-module ff_lane: a combinational next-state and illegal-flag for one bit, given mode, j, k and q. Instantiated WIDTH times via generate.
- Top level holds the q, changed, sr_err and toggle_cnt registers plus the saturation logic.

## Test plan
All scenarios use WIDTH=8 and CNT_W=4.
- Reset, then load=1 with load_data=8'hA5 → q=A5, changed=A5, toggle_cnt=4, q_n=5A.
- From q=A5, JK mode, en=1, j=8'hF0, k=8'h0F, one edge → q=F0, changed=55, toggle_cnt=8.
- From q=F0, SR mode, en=1, j=8'h81, k=8'h01 → q=F0 (lane 0: S=R=1 holds; lane 7 already set), changed=00, sr_err=1. Next edge with err_clr=1 and the same inputs → sr_err stays 1. Next edge with err_clr=1 and en=0 → sr_err=0.
- T mode, en=1, j=8'hFF held for 3 edges from q=00 → q alternates FF, 00, FF; toggle_cnt saturates at 15 and does not wrap.
- D mode with en=0, j=8'h3C → q holds, changed=00. The same edge with load=1 and load_data=8'h11 → q=11 (load overrides en=0).
- From q=FF with toggle_cnt nonzero, assert rst together with load=1 and en=1 → q=RST_VAL, changed=0, sr_err=0, toggle_cnt=0 after one edge.
